// File: rtl/ob_table_cnt_cpa.sv
// Pipelined carry-propagate adder: resolves a CSA sum/carry pair, SEG bits per stage.
// Optional sticky overflow flag when OB_TABLE_CNT_CPA_OVF_EN is defined.
module ob_table_cnt_cpa #(
  parameter int W   = 32,
  parameter int SEG = 8
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_s_w,
  input  logic [W-1:0] in_c_w,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
`ifdef OB_TABLE_CNT_CPA_OVF_EN
  input  logic         ovf_clr,
  output logic         out_ovf,
`endif
  input  logic         out_rdy
);

  localparam int K = W / SEG;

  if ((SEG < 1) || ((W % SEG) != 0)) begin : g_bad_cfg
    $fatal(1, "ob_table_cnt_cpa: W must be a positive multiple of SEG");
  end

  // Whole pipe moves as one; bubbles are carried, never squeezed out.
  logic adv;
  assign adv    = !out_vld || out_rdy;
  assign in_rdy = adv;

  for (genvar gi = 0; gi < K; gi++) begin : g_stage
    localparam int LO = gi * SEG;
    localparam int CW = W - LO;

    // a word: bits below LO already resolved, bits at/above LO still raw s
    logic [W-1:0]  a_in;
    logic [CW-1:0] c_in;
    logic          cin;
    logic          v_in;
    logic [SEG:0]  sum_ch;
    logic [W-1:0]  a_d;
    logic [W-1:0]  a_q;
    logic          cy_q;
    logic          v_q;

    if (gi == 0) begin : g_head
      assign a_in = in_s_w;
      assign c_in = in_c_w;
      assign cin  = 1'b0;
      assign v_in = in_vld;
    end else begin : g_body
      assign a_in = g_stage[gi-1].a_q;
      assign c_in = g_stage[gi-1].g_cp.cp_q;
      assign cin  = g_stage[gi-1].cy_q;
      assign v_in = g_stage[gi-1].v_q;
    end

    assign sum_ch = {1'b0, a_in[LO +: SEG]} + {1'b0, c_in[SEG-1:0]} + {{SEG{1'b0}}, cin};

    always_comb begin
      a_d            = a_in;
      a_d[LO +: SEG] = sum_ch[SEG-1:0];
    end

    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        v_q  <= 1'b0;
        cy_q <= 1'b0;
        a_q  <= '0;
      end else if (adv) begin
        v_q  <= v_in;
        cy_q <= sum_ch[SEG];
        a_q  <= a_d;
      end
    end

    // Only the still-unconsumed upper carry-word bits travel downstream.
    if (gi < K - 1) begin : g_cp
      logic [CW-SEG-1:0] cp_q;
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          cp_q <= '0;
        end else if (adv) begin
          cp_q <= c_in[CW-1:SEG];
        end
      end
    end
  end

  assign out_vld  = g_stage[K-1].v_q;
  assign out_sum  = g_stage[K-1].a_q;
  assign out_cout = g_stage[K-1].cy_q;

`ifdef OB_TABLE_CNT_CPA_OVF_EN
  // A new overflow on the same cycle as a clear wins, so no event is lost.
  logic ovf_q;
  logic ovf_d;
  assign ovf_d = (ovf_q && !ovf_clr) || (out_vld && out_rdy && out_cout);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign out_ovf = ovf_q;
`endif

endmodule
